control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 45 ++++
 rtl/control_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Control bus between the LC-3b style control unit and its datapath.
interface control_unit_if;
  logic [15:0] opcode;
  logic        N;
  logic        Z;
  logic        P;

  logic        marE;
  logic        mdrE;
  logic        irE;
  logic        pcE;
  logic        regWriteE;
  logic        nzpE;
  logic        memWriteE;

  logic        marmux;
  logic        srmux;
  logic        drmux;
  logic        adjmux;
  logic        mdrmux;
  logic        mdrControl;
  logic        lshift;

  logic [1:0]  pcmux;
  logic [1:0]  regmux;
  logic [1:0]  opmux;
  logic [2:0]  aluControl;
  logic [3:0]  state;

  // Control unit side: consumes IR and condition codes, drives controls.
  modport master (
    input  opcode, N, Z, P,
    output marE, mdrE, irE, pcE, regWriteE, nzpE, memWriteE,
    output marmux, srmux, drmux, adjmux, mdrmux, mdrControl, lshift,
    output pcmux, regmux, opmux, aluControl, state
  );

  // Datapath side.
  modport slave (
    output opcode, N, Z, P,
    input  marE, mdrE, irE, pcE, regWriteE, nzpE, memWriteE,
    input  marmux, srmux, drmux, adjmux, mdrmux, mdrControl, lshift,
    input  pcmux, regmux, opmux, aluControl, state
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch, decode and execute control.
// Outputs are a decode of the registered state; only the IR fields and,
// in BR, the sampled condition codes refine them.
module control_unit (
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    FETCH1 = 4'd0,  FETCH2 = 4'd1,  FETCH3 = 4'd2,  DECODE = 4'd3,
    ALU    = 4'd4,  BR     = 4'd5,  JMP    = 4'd6,  JSR    = 4'd7,
    LEA    = 4'd8,  LD1    = 4'd9,  LD2    = 4'd10, LD3    = 4'd11,
    ST1    = 4'd12, ST2    = 4'd13, ST3    = 4'd14
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_AND   = 3'd1;
  localparam logic [2:0] ALU_XOR   = 3'd2;
  localparam logic [2:0] ALU_PASSA = 3'd3;

  localparam logic [1:0] PC_ADDER  = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  localparam logic [1:0] REG_MDR   = 2'd1;
  localparam logic [1:0] REG_ADDER = 2'd2;
  localparam logic [1:0] REG_PC    = 2'd3;

  localparam logic [1:0] OP_IMM5   = 2'd1;
  localparam logic [1:0] OP_OFF6   = 2'd2;

  state_e     state_q;
  state_e     state_d;
  logic [3:0] op_class;
  logic       br_taken;
  logic       unused_ok;

  logic       mar_e, mdr_e, ir_e, pc_e, reg_we, nzp_e, mem_we;
  logic       marmux, srmux, drmux, adjmux, mdrmux, mdr_ctl, lshift;
  logic [1:0] pcmux, regmux, opmux;
  logic [2:0] alu_ctl;

  assign op_class  = bus.opcode[15:12];
  assign br_taken  = (bus.opcode[11] & bus.N) | (bus.opcode[10] & bus.Z) |
                     (bus.opcode[9] & bus.P);
  assign unused_ok = ^{bus.opcode[8:6], bus.opcode[4:0]};

  // State register; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH1;
    else       state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = FETCH1;
    case (state_q)
      FETCH1: state_d = FETCH2;
      FETCH2: state_d = FETCH3;
      FETCH3: state_d = DECODE;
      DECODE: begin
        case (op_class)
          4'b0001, 4'b0101, 4'b1001: state_d = ALU;
          4'b0000:                   state_d = BR;
          4'b1100:                   state_d = JMP;
          4'b0100:                   state_d = JSR;
          4'b1110:                   state_d = LEA;
          4'b0110:                   state_d = LD1;
          4'b0111:                   state_d = ST1;
          default:                   state_d = FETCH1;
        endcase
      end
      LD1:     state_d = LD2;
      LD2:     state_d = LD3;
      ST1:     state_d = ST2;
      ST2:     state_d = ST3;
      default: state_d = FETCH1;
    endcase
  end

  // Per-state control decode; everything not named stays 0.
  always_comb begin
    mar_e   = 1'b0; mdr_e  = 1'b0; ir_e   = 1'b0; pc_e   = 1'b0;
    reg_we  = 1'b0; nzp_e  = 1'b0; mem_we = 1'b0;
    marmux  = 1'b0; srmux  = 1'b0; drmux  = 1'b0; adjmux = 1'b0;
    mdrmux  = 1'b0; mdr_ctl = 1'b0; lshift = 1'b0;
    pcmux   = 2'd0; regmux = 2'd0; opmux  = 2'd0;
    alu_ctl = ALU_ADD;
    case (state_q)
      FETCH1: begin
        mar_e = 1'b1;
        pc_e  = 1'b1;
      end
      FETCH2: begin
        mdr_e   = 1'b1;
        mdr_ctl = 1'b1;
      end
      FETCH3: ir_e = 1'b1;
      ALU: begin
        reg_we = 1'b1;
        nzp_e  = 1'b1;
        opmux  = bus.opcode[5] ? OP_IMM5 : 2'd0;
        case (op_class)
          4'b0101: alu_ctl = ALU_AND;
          4'b1001: alu_ctl = ALU_XOR;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      BR: begin
        if (br_taken) begin
          pc_e   = 1'b1;
          pcmux  = PC_ADDER;
          lshift = 1'b1;
        end
      end
      JMP: begin
        alu_ctl = ALU_PASSA;
        pc_e    = 1'b1;
        pcmux   = PC_ALU;
      end
      JSR: begin
        reg_we = 1'b1;
        regmux = REG_PC;
        drmux  = 1'b1;
        pc_e   = 1'b1;
        pcmux  = PC_ADDER;
        adjmux = 1'b1;
      end
      LEA: begin
        reg_we = 1'b1;
        regmux = REG_ADDER;
      end
      LD1, ST1: begin
        mar_e  = 1'b1;
        marmux = 1'b1;
        opmux  = OP_OFF6;
        lshift = 1'b1;
      end
      LD2: begin
        mdr_e   = 1'b1;
        mdr_ctl = 1'b1;
      end
      LD3: begin
        reg_we = 1'b1;
        regmux = REG_MDR;
        nzp_e  = 1'b1;
      end
      ST2: begin
        mdr_e   = 1'b1;
        mdrmux  = 1'b1;
        srmux   = 1'b1;
        alu_ctl = ALU_PASSA;
      end
      ST3: begin
        mem_we  = 1'b1;
        mdr_ctl = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are held off for as long as reset is asserted.
  assign bus.marE       = mar_e  & ~reset;
  assign bus.mdrE       = mdr_e  & ~reset;
  assign bus.irE        = ir_e   & ~reset;
  assign bus.pcE        = pc_e   & ~reset;
  assign bus.regWriteE  = reg_we & ~reset;
  assign bus.nzpE       = nzp_e  & ~reset;
  assign bus.memWriteE  = mem_we & ~reset;
  assign bus.marmux     = marmux;
  assign bus.srmux      = srmux;
  assign bus.drmux      = drmux;
  assign bus.adjmux     = adjmux;
  assign bus.mdrmux     = mdrmux;
  assign bus.mdrControl = mdr_ctl;
  assign bus.lshift     = lshift;
  assign bus.pcmux      = pcmux;
  assign bus.regmux     = regmux;
  assign bus.opmux      = opmux;
  assign bus.aluControl = alu_ctl;
  assign bus.state      = state_q;

endmodule
